// File: rtl/counter_scheduler.sv
// Round-robin owner of a shared step-by-2 counter: grants it to one requester
// per run, drives its mode/restart, and returns the tagged counted sequence.
module counter_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4,
  parameter int LEN_WIDTH = 4
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ-1:0]             ReqMode,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   ReqLen,
  output logic [NUM_REQ-1:0]             Grant,
  output logic                           CntOp,
  output logic                           CntRst_n,
  input  logic [CNT_WIDTH-1:0]           CntIn,
  output logic [CNT_WIDTH-1:0]           DataOut,
  output logic                           DataValid,
  output logic [$clog2(NUM_REQ)-1:0]     DataOwner,
  output logic [NUM_REQ-1:0]             Done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_owner;
  logic                   r_mode;
  logic [LEN_WIDTH-1:0]   r_remain;

  logic [NUM_REQ-1:0]     r_grant;
  logic                   r_cnt_op;
  logic                   r_cnt_rst_n;
  logic [CNT_WIDTH-1:0]   r_data;
  logic                   r_valid;
  logic [IDX_W-1:0]       r_data_owner;
  logic [NUM_REQ-1:0]     r_done;

  logic                   w_found;
  logic [IDX_W-1:0]       w_win;
  logic [NUM_REQ-1:0]     w_win_oh;
  logic [IDX_W-1:0]       w_ptr_nxt;
  logic [LEN_WIDTH-1:0]   w_len_sel;
  logic [LEN_WIDTH-1:0]   w_len_eff;
  logic                   w_last;
  logic [NUM_REQ-1:0]     w_grant_nxt;
  logic                   w_op_nxt;
  logic                   w_rstn_nxt;

  // Round-robin: first requester at or above the pointer, else wrap to the lowest.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && Req[i] && (i >= 32'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && Req[i]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  assign w_ptr_nxt = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_len_sel = ReqLen[int'(w_win) * LEN_WIDTH +: LEN_WIDTH];
  assign w_len_eff = (w_len_sel == '0) ? LEN_ONE : w_len_sel;
  assign w_last    = (r_remain == LEN_ONE);

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_op_nxt    = 1'b0;
    w_rstn_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_START;
          w_grant_nxt = w_win_oh;
          w_op_nxt    = ReqMode[w_win];
        end
      end
      ST_START: begin
        w_state_nxt = ST_RUN;
        w_grant_nxt = r_grant;
        w_op_nxt    = r_mode;
        w_rstn_nxt  = 1'b1;
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_grant_nxt = r_grant;
          w_op_nxt    = r_mode;
          w_rstn_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr        <= '0;
      r_owner      <= '0;
      r_mode       <= 1'b0;
      r_remain     <= '0;
      r_grant      <= '0;
      r_cnt_op     <= 1'b0;
      r_cnt_rst_n  <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_data_owner <= '0;
      r_done       <= '0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_cnt_op    <= w_op_nxt;
      r_cnt_rst_n <= w_rstn_nxt;

      if ((r_state == ST_IDLE) && w_found) begin
        r_owner  <= w_win;
        r_mode   <= ReqMode[w_win];
        r_remain <= w_len_eff;
        r_ptr    <= w_ptr_nxt;
      end

      if (r_state == ST_RUN) begin
        r_data       <= CntIn;
        r_valid      <= 1'b1;
        r_data_owner <= r_owner;
        r_done       <= w_last ? r_grant : '0;
        r_remain     <= r_remain - LEN_ONE;
      end else begin
        r_valid <= 1'b0;
        r_done  <= '0;
      end
    end
  end

  assign Grant     = r_grant;
  assign CntOp     = r_cnt_op;
  assign CntRst_n  = r_cnt_rst_n;
  assign DataOut   = r_data;
  assign DataValid = r_valid;
  assign DataOwner = r_data_owner;
  assign Done      = r_done;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: attached step-by-2 counter, directed and random
// requests, checked cycle by cycle against a run-timeline model.
module tb_counter_scheduler;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int LW   = 4;
  localparam int IW   = 2;
  localparam int MAXC = 4096;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req   = '0;
  logic [N-1:0]      mode  = '0;
  logic [N*LW-1:0]   len   = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              cnt_op;
  logic              cnt_rst_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     data;
  logic              valid;
  logic [IW-1:0]     owner;

  int unsigned e_grant [MAXC];
  int unsigned e_op    [MAXC];
  int unsigned e_rstn  [MAXC];
  int unsigned e_valid [MAXC];
  int unsigned e_data  [MAXC];
  int unsigned e_owner [MAXC];
  int unsigned e_done  [MAXC];

  int unsigned cyc       = 0;
  int unsigned free_at   = 0;
  int unsigned ptr       = 0;
  int unsigned last_data = 0;
  int unsigned n_total   = 0;
  int unsigned n_bad     = 0;

  always #5 clk = ~clk;

  // The shared counter: synchronous restart to its base, otherwise +2 mod 2^CW.
  always @(posedge clk) begin
    if (!cnt_rst_n) cnt <= {{(CW-1){1'b0}}, cnt_op};
    else            cnt <= cnt + CW'(2);
  end

  counter_scheduler #(
    .NUM_REQ  (N),
    .CNT_WIDTH(CW),
    .LEN_WIDTH(LW)
  ) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Req      (req),
    .ReqMode  (mode),
    .ReqLen   (len),
    .Grant    (grant),
    .CntOp    (cnt_op),
    .CntRst_n (cnt_rst_n),
    .CntIn    (cnt),
    .DataOut  (data),
    .DataValid(valid),
    .DataOwner(owner),
    .Done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N*LW-1:0] mk(input int unsigned a, b, c, d);
    return {LW'(d), LW'(c), LW'(b), LW'(a)};
  endfunction

  task automatic check_outputs();
    check("grant", 32'(grant), e_grant[cyc]);
    check("cntop", 32'(cnt_op), e_op[cyc]);
    check("cntrstn", 32'(cnt_rst_n), e_rstn[cyc]);
    check("valid", 32'(valid), e_valid[cyc]);
    check("done", 32'(done), e_done[cyc]);
    if (e_valid[cyc] != 0) begin
      last_data = e_data[cyc];
      check("owner", 32'(owner), e_owner[cyc]);
    end
    check("data", 32'(data), last_data);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_grant"}, 32'(grant), 0);
    check({pfx, "_cntop"}, 32'(cnt_op), 0);
    check({pfx, "_cntrstn"}, 32'(cnt_rst_n), 0);
    check({pfx, "_data"}, 32'(data), 0);
    check({pfx, "_valid"}, 32'(valid), 0);
    check({pfx, "_owner"}, 32'(owner), 0);
    check({pfx, "_done"}, 32'(done), 0);
  endtask

  task automatic clear_model(input int unsigned from);
    for (int unsigned t = from; t < from + 24 && t < MAXC; t++) begin
      e_grant[t] = 0; e_op[t] = 0; e_rstn[t] = 0; e_valid[t] = 0;
      e_data[t] = 0;  e_owner[t] = 0; e_done[t] = 0;
    end
  endtask

  // A request seen in a free cycle c occupies c+1..c+L+1 and yields data in c+3..c+L+2.
  task automatic sched(input int unsigned c);
    int unsigned w, l, base;
    bit found;
    if (!rst_n || c < free_at || req == '0) return;
    found = 0;
    w = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[(ptr + k) % N]) begin
        found = 1;
        w = (ptr + k) % N;
      end
    end
    l = len[w*LW +: LW];
    if (l == 0) l = 1;
    base = mode[w];
    for (int unsigned t = c + 1; t <= c + l + 1; t++) begin
      e_grant[t] = 1 << w;
      e_op[t]    = base;
    end
    for (int unsigned t = c + 2; t <= c + l + 1; t++) e_rstn[t] = 1;
    for (int unsigned k = 0; k < l; k++) begin
      e_valid[c + 3 + k] = 1;
      e_data[c + 3 + k]  = (base + 2 * k) % (1 << CW);
      e_owner[c + 3 + k] = w;
    end
    e_done[c + l + 2] = 1 << w;
    ptr     = (w + 1) % N;
    free_at = c + l + 2;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] m,
                      input logic [N*LW-1:0] l, input logic rv);
    @(negedge clk);
    check_outputs();
    if (!rv) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      clear_model(cyc + 1);
      ptr       = 0;
      free_at   = 0;
      last_data = 0;
    end else begin
      rst_n = 1'b1;
    end
    req  = r;
    mode = m;
    len  = l;
    sched(cyc);
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step('0, '0, '0, 1'b1);
  endtask

  int unsigned     rst_hold = 0;
  logic [N-1:0]    rr;
  logic [N-1:0]    rm;
  logic [N*LW-1:0] rlen;

  initial begin
    #1;
    check_reset_outputs("rst");

    idle(2);
    step(4'b0001, 4'b0001, mk(3, 0, 0, 0), 1'b1);
    idle(6);
    step(4'b0100, 4'b0000, mk(0, 0, 10, 0), 1'b1);
    idle(13);
    repeat (10) step(4'b1111, 4'b0101, mk(1, 1, 1, 1), 1'b1);
    idle(3);
    repeat (8) step(4'b1010, 4'b0010, mk(0, 2, 0, 2), 1'b1);
    idle(4);
    step(4'b0001, 4'b0001, mk(0, 0, 0, 0), 1'b1);
    idle(4);
    step(4'b0100, 4'b0000, mk(0, 0, 5, 0), 1'b1);
    idle(2);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    step(4'b1010, 4'b0000, mk(1, 1, 1, 1), 1'b1);
    idle(5);

    for (int n = 0; n < 1800; n++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        step('0, '0, '0, 1'b0);
      end else begin
        if ($urandom_range(0, 299) == 0) rst_hold = 2;
        rr   = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
        rm   = N'($urandom);
        rlen = (N*LW)'($urandom);
        step(rr, rm, rlen, 1'b1);
      end
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
